// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scan-out reads win every cycle with fixed 3-cycle latency,
// writer traffic is queued in a small FIFO and drained into idle RAM slots.
module vga_fb_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 3,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              wr_starve,
  input  logic              starve_clr,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fifo_addr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_d [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;

  logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic              v0_q, v0_d, v1_q, v1_d, rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic              starve_q, starve_d;

  logic full, empty, push, pop, starve_cond;

  always_comb begin
    full  = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    empty = (wp_q == rp_q);
    push  = wr_req && !full;
    pop   = !rd_req && !empty;

    fifo_addr_d = fifo_addr_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_addr_d[wp_q[AW-1:0]] = wr_addr;
      fifo_data_d[wp_q[AW-1:0]] = wr_data;
    end
    wp_d = wp_q + PW'(push);
    rp_d = rp_q + PW'(pop);

    // Reads always take the slot; idle slots drain the FIFO head.
    mem_en_d    = rd_req || pop;
    mem_we_d    = pop;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (rd_req) begin
      mem_addr_d = rd_addr;
    end else if (pop) begin
      mem_addr_d  = fifo_addr_q[rp_q[AW-1:0]];
      mem_wdata_d = fifo_data_q[rp_q[AW-1:0]];
    end

    v0_d       = rd_req;
    v1_d       = v0_q;
    rd_valid_d = v1_q;
    rd_data_d  = v1_q ? mem_rdata : rd_data_q;

    starve_cond = rd_req && !empty;
    cnt_d       = '0;
    if (starve_cond) begin
      cnt_d = (cnt_q == CW'(STARVE_LIMIT)) ? cnt_q : cnt_q + CW'(1);
    end
    // Set has priority over a simultaneous clear.
    starve_d = (starve_cond && (cnt_d == CW'(STARVE_LIMIT))) || (starve_q && !starve_clr);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_addr_q[i] <= '0;
        fifo_data_q[i] <= '0;
      end
      wp_q        <= '0;
      rp_q        <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      v0_q        <= 1'b0;
      v1_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      cnt_q       <= '0;
      starve_q    <= 1'b0;
    end else begin
      fifo_addr_q <= fifo_addr_d;
      fifo_data_q <= fifo_data_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      v0_q        <= v0_d;
      v1_q        <= v1_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
    end
  end

  assign wr_ready  = !full;
  assign wr_starve = starve_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;

endmodule
